// File: rtl/phase_array_gen.sv
// Multi-channel phase-shifted square-wave generator. Per-channel phase offsets arrive
// as checksummed UART frames and take effect only at a waveform period boundary.
module phase_array_gen #(
    parameter int CH  = 8,
    parameter int PW  = 8,
    parameter int DIV = 25,
    parameter int TMO = 100000
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_int,
    input  logic          run,
    output logic [CH-1:0] z,
    output logic          frame_ok,
    output logic          frame_err,
    output logic          busy
);
    localparam int IW = (CH > 1) ? $clog2(CH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW = $clog2(TMO);
    localparam logic [7:0]    HEADER   = 8'hAA;
    localparam logic [IW-1:0] LAST_IDX = IW'(CH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    typedef enum logic [1:0] {
        IDLE,
        PHASE,
        CHK
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            phase_stb;
    logic            chk_stb;
    logic            timeout;
    logic            chk_match;
    logic            commit;
    logic            pc_wrap;
    logic            promote;

    logic [IW-1:0]   idx;
    logic [7:0]      xor_acc;
    logic [TW-1:0]   tmo_cnt;
    logic [DW-1:0]   presc;
    logic [PW-1:0]   pc;
    logic            pending;
    logic [PW-1:0]   rx_buf [CH];
    logic [PW-1:0]   shadow [CH];
    logic [PW-1:0]   active [CH];
    logic [PW-1:0]   lag    [CH];
    logic [CH-1:0]   z_nxt;

    // ---------------- parser FSM ----------------
    // NOTE: state is sequential, so it is assigned with <= to avoid ordering races.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt defaults to state so every path assigns it and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = IDLE;
        end else if (rx_int) begin
            case (state)
                IDLE:    if (rx_data == HEADER) state_nxt = PHASE;
                PHASE:   if (idx == LAST_IDX)   state_nxt = CHK;
                CHK:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        phase_stb = rx_int && (state == PHASE);
        chk_stb   = rx_int && (state == CHK);
    end

    // A byte arriving in the same cycle as expiry wins, so timeout requires rx_int low.
    assign timeout   = busy && !rx_int && (tmo_cnt == TMO_LAST);
    assign chk_match = (rx_data == xor_acc);
    assign commit    = chk_stb && chk_match;

    // ---------------- frame datapath ----------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            idx       <= '0;
            xor_acc   <= '0;
            tmo_cnt   <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_ok  <= commit;
            frame_err <= timeout || (chk_stb && !chk_match);

            if (!busy || rx_int || timeout) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (state == IDLE) begin
                idx     <= '0;
                xor_acc <= '0;
            end else if (phase_stb) begin
                idx     <= idx + 1'b1;
                xor_acc <= xor_acc ^ rx_data;
            end
        end
    end

    // NOTE: rx_buf has no reset; every entry is rewritten before a checksum can commit it.
    always_ff @(posedge sys_clk) begin
        if (phase_stb) begin
            rx_buf[idx] <= rx_data[PW-1:0];
        end
    end

    // Bytes are staged in rx_buf so a corrupt or abandoned frame never touches shadow.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            pending <= 1'b0;
        end else begin
            if (promote) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            if (commit) begin
                shadow  <= rx_buf;
                pending <= 1'b1;
            end
        end
    end

    // ---------------- phase counter ----------------
    assign pc_wrap = run && (presc == DIV_LAST) && (&pc);
    assign promote = pending && (!run || pc_wrap);

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !run) begin
            presc <= '0;
            pc    <= '0;
        end else if (presc == DIV_LAST) begin
            presc <= '0;
            pc    <= pc + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // High for the first half period after the channel's own phase origin.
    always_comb begin
        z_nxt = '0;
        for (int i = 0; i < CH; i++) begin
            lag[i]   = pc - active[i];
            z_nxt[i] = run && !lag[i][PW-1];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            z <= '0;
        end else begin
            z <= z_nxt;
        end
    end

endmodule
